// File: rtl/spi_flash_target.sv
// SPI mode-0 serial flash responder, 16-bit addressing, AND-only program.
// Optional CHIP_ERASE_EN macro enables the 0xC7 chip erase sweep.
module spi_flash_target #(
    parameter int ADDR_W      = 16,
    parameter int MEM_DEPTH   = 256,
    parameter int PROG_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic spi_clk,
    input  logic spi_cs,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic wip,
    output logic wel,
    output logic cmd_err
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int WC_W  = $clog2(PROG_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR_HI, ADDR_LO,
        READ_DATA, PROG_DATA, STATUS, IGNORE
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE, OP_WREN, OP_WRDI,
        OP_READ, OP_PROG, OP_ERASE
    } op_t;

    state_t            state;
    op_t               op;
    logic [1:0]        sclk_s, cs_s, mosi_s;
    logic              sclk_d, cs_d;
    logic [2:0]        bit_cnt;
    logic [6:0]        rx;
    logic [7:0]        tx;
    logic [ADDR_W-1:0] addr;
    logic              prog_any;
    logic [WC_W-1:0]   wip_cnt;
`ifdef CHIP_ERASE_EN
    logic              erase_busy;
    logic [IDX_W-1:0]  erase_idx;
`endif

    // Stores cleared bits, so the all-zero power-up state reads as erased.
    logic [7:0]        mem_clr [MEM_DEPTH];
    logic              mem_we;
    logic [IDX_W-1:0]  mem_wa;
    logic [7:0]        mem_wd;

    logic              sclk_rise, sclk_fall, cs_fall, cs_rise, cs_high;
    logic              byte_done;
    logic [7:0]        rx_byte, rd_data, status;
    logic [ADDR_W-1:0] full_addr;
    logic [IDX_W-1:0]  rd_idx;

    assign cs_high   = cs_s[1];
    assign sclk_rise = sclk_s[1] & ~sclk_d;
    assign sclk_fall = ~sclk_s[1] & sclk_d;
    assign cs_fall   = ~cs_s[1] & cs_d;
    assign cs_rise   = cs_s[1] & ~cs_d;
    assign byte_done = sclk_rise && (bit_cnt == 3'd7);
    assign rx_byte   = {rx, mosi_s[1]};
    assign full_addr = {addr[ADDR_W-9:0], rx_byte};
    assign rd_idx    = (state == ADDR_LO) ? full_addr[IDX_W-1:0]
                                          : addr[IDX_W-1:0];
    assign rd_data   = ~mem_clr[rd_idx];
    assign status    = {6'b0, wel, wip};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_s <= '0;
            cs_s   <= '0;
            mosi_s <= '0;
            sclk_d <= 1'b0;
            cs_d   <= 1'b0;
        end else begin
            sclk_s <= {sclk_s[0], spi_clk};
            cs_s   <= {cs_s[0], spi_cs};
            mosi_s <= {mosi_s[0], spi_mosi};
            sclk_d <= sclk_s[1];
            cs_d   <= cs_s[1];
        end
    end

    always_comb begin
        mem_we = 1'b0;
        mem_wa = addr[IDX_W-1:0];
        mem_wd = mem_clr[addr[IDX_W-1:0]] | ~rx_byte;
        if (!cs_high && state == PROG_DATA && byte_done)
            mem_we = 1'b1;
`ifdef CHIP_ERASE_EN
        if (erase_busy) begin
            mem_we = 1'b1;
            mem_wa = erase_idx;
            mem_wd = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem_clr[mem_wa] <= mem_wd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            op       <= OP_NONE;
            bit_cnt  <= '0;
            rx       <= '0;
            tx       <= '0;
            addr     <= '0;
            prog_any <= 1'b0;
            wip_cnt  <= '0;
            wip      <= 1'b0;
            wel      <= 1'b0;
            cmd_err  <= 1'b0;
            spi_miso <= 1'b0;
`ifdef CHIP_ERASE_EN
            erase_busy <= 1'b0;
            erase_idx  <= '0;
`endif
        end else begin
            cmd_err <= 1'b0;
`ifdef CHIP_ERASE_EN
            if (erase_busy) begin
                erase_idx <= erase_idx + 1'b1;
                if (erase_idx == IDX_W'(MEM_DEPTH - 1)) begin
                    erase_busy <= 1'b0;
                    wip        <= 1'b0;
                    wel        <= 1'b0;
                end
            end else
`endif
            if (wip) begin
                if (wip_cnt == '0)
                    wip <= 1'b0;
                else
                    wip_cnt <= wip_cnt - 1'b1;
            end

            if (cs_high) begin
                state    <= IDLE;
                op       <= OP_NONE;
                bit_cnt  <= '0;
                tx       <= '0;
                prog_any <= 1'b0;
                spi_miso <= 1'b0;
                if (cs_rise) begin
                    case (op)
                        OP_WREN: wel <= 1'b1;
                        OP_WRDI: wel <= 1'b0;
                        OP_PROG: begin
                            if (prog_any) begin
                                wip     <= 1'b1;
                                wip_cnt <= WC_W'(PROG_CYCLES - 1);
                                wel     <= 1'b0;
                            end
                        end
`ifdef CHIP_ERASE_EN
                        OP_ERASE: begin
                            wip        <= 1'b1;
                            erase_busy <= 1'b1;
                            erase_idx  <= '0;
                        end
`endif
                        default: ;
                    endcase
                end
            end else if (state == IDLE) begin
                if (cs_fall) begin
                    state   <= CMD;
                    bit_cnt <= '0;
                    tx      <= '0;
                end
            end else begin
                if (sclk_fall) begin
                    spi_miso <= tx[7];
                    tx       <= {tx[6:0], 1'b0};
                end
                if (sclk_rise) begin
                    rx      <= rx_byte[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (byte_done) begin
                    case (state)
                        CMD: begin
                            // Busy device only answers status polls.
                            if (wip && rx_byte != 8'h05) begin
                                state <= IGNORE;
                            end else begin
                                case (rx_byte)
                                    8'h06: begin
                                        op    <= OP_WREN;
                                        state <= IGNORE;
                                    end
                                    8'h04: begin
                                        op    <= OP_WRDI;
                                        state <= IGNORE;
                                    end
                                    8'h05: begin
                                        state <= STATUS;
                                        tx    <= status;
                                    end
                                    8'h03: begin
                                        op    <= OP_READ;
                                        state <= ADDR_HI;
                                    end
                                    8'h02: begin
                                        if (wel) begin
                                            op    <= OP_PROG;
                                            state <= ADDR_HI;
                                        end else begin
                                            cmd_err <= 1'b1;
                                            state   <= IGNORE;
                                        end
                                    end
`ifdef CHIP_ERASE_EN
                                    8'hC7: begin
                                        state <= IGNORE;
                                        if (wel)
                                            op <= OP_ERASE;
                                        else
                                            cmd_err <= 1'b1;
                                    end
`endif
                                    default: begin
                                        cmd_err <= 1'b1;
                                        state   <= IGNORE;
                                    end
                                endcase
                            end
                        end
                        ADDR_HI: begin
                            addr  <= full_addr;
                            state <= ADDR_LO;
                        end
                        ADDR_LO: begin
                            if (op == OP_READ) begin
                                tx    <= rd_data;
                                addr  <= full_addr + 1'b1;
                                state <= READ_DATA;
                            end else begin
                                addr  <= full_addr;
                                state <= PROG_DATA;
                            end
                        end
                        READ_DATA: begin
                            tx   <= rd_data;
                            addr <= addr + 1'b1;
                        end
                        PROG_DATA: begin
                            addr     <= addr + 1'b1;
                            prog_any <= 1'b1;
                        end
                        STATUS: tx <= status;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
